// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: state, opcode, ALU and immediate encodings for the multicycle RV32I controller
package rv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB, S_LUI, S_AUIPC, S_TRAP
  } state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_ctrl_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_PASSB} alu_op_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and funct fields to the ALU operation code
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       op5,
  output logic [3:0] alu_control
);
  logic [3:0] f;
  always_comb begin
    f = ALU_ADD;
    case (funct3)
      3'b000: f = (op5 & funct7) ? ALU_SUB : ALU_ADD;
      3'b001: f = ALU_SLL;
      3'b010: f = ALU_SLT;
      3'b011: f = ALU_SLTU;
      3'b100: f = ALU_XOR;
      3'b101: f = funct7 ? ALU_SRA : ALU_SRL;
      3'b110: f = ALU_OR;
      3'b111: f = ALU_AND;
    endcase
    alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  alu_op == ALUOP_PASSB ? ALU_PASSB : f;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RV32I datapath with memory handshake and illegal-opcode trap
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [3:0] Flags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);
  state_t state, state_n;
  logic rdy, taken, pc_update, branch, mem_we, ir_we, reg_we;
  logic [1:0] alu_op;
  logic n, z, c, v;
  assign {n, z, c, v} = Flags;
  assign rdy = mem_ready | ~USE_MEM_READY;
  assign state_dbg = state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= state_n;
  always_comb begin
    taken = funct3 == 3'b000 ? z :
            funct3 == 3'b001 ? ~z :
            funct3 == 3'b100 ? n ^ v :
            funct3 == 3'b101 ? ~(n ^ v) :
            funct3 == 3'b110 ? ~c :
            funct3 == 3'b111 ? c : 1'b0;
    ImmSrc = opcode == OP_STORE ? IMM_S :
             opcode == OP_BRANCH ? IMM_B :
             opcode == OP_JAL ? IMM_J :
             (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U : IMM_I;
  end
  always_comb begin
    state_n = state;
    pc_update = 1'b0;
    branch = 1'b0;
    mem_we = 1'b0;
    ir_we = 1'b0;
    reg_we = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'd0;
    ALUSrcA = 2'd0;
    ALUSrcB = 2'd0;
    alu_op = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        ir_we = rdy;
        pc_update = rdy;
        ALUSrcB = 2'd2;
        ResultSrc = 2'd2;
        if (rdy) state_n = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        case (opcode)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_R:      state_n = S_EXECR;
          OP_I:      state_n = S_EXECI;
          OP_JAL:    state_n = S_JAL;
          OP_JALR:   state_n = S_JALR;
          OP_BRANCH: state_n = S_BRANCH;
          OP_LUI:    state_n = S_LUI;
          OP_AUIPC:  state_n = S_AUIPC;
          default:   state_n = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        state_n = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (rdy) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'd1;
        reg_we = 1'b1;
        state_n = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        if (rdy) state_n = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'd2;
        alu_op = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        alu_op = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'd2;
        alu_op = ALUOP_SUB;
        branch = 1'b1;
        state_n = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        pc_update = 1'b1;
        state_n = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        ResultSrc = 2'd2;
        pc_update = 1'b1;
        state_n = S_JALWB;
      end
      S_JALWB: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ResultSrc = 2'd2;
        reg_we = 1'b1;
        state_n = S_FETCH;
      end
      S_LUI: begin
        ALUSrcB = 2'd1;
        alu_op = ALUOP_PASSB;
        state_n = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        state_n = S_ALUWB;
      end
      S_TRAP: illegal_instr = 1'b1;
    endcase
  end
  // FETCH enables depend on mem_ready, so gate them with reset to keep every write off while reset is held
  assign PCWrite  = reset & (pc_update | (branch & taken));
  assign MemWrite = reset & mem_we;
  assign IRWrite  = reset & ir_we;
  assign RegWrite = reset & reg_we;
  alu_decoder u_alu_dec (
    .alu_op(alu_op),
    .funct3(funct3),
    .funct7(funct7),
    .op5(opcode[5]),
    .alu_control(ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: vector table, corner sequences and queue-modelled random instructions
module tb_multicycle_controller;
  import rv_ctrl_pkg::*;
  logic clk = 1'b0, reset = 1'b0;
  logic [6:0] opcode = 7'h33;
  logic [2:0] funct3 = 3'd0;
  logic funct7 = 1'b0, mem_ready = 1'b1;
  logic [3:0] Flags = 4'd0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control, state_dbg;
  logic [2:0] imm_src;
  logic pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal_instr2;
  logic [1:0] result_src2, alu_src_a2, alu_src_b2;
  logic [3:0] alu_control2, state_dbg2;
  logic [2:0] imm_src2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Flags(Flags), .mem_ready(mem_ready), .PCWrite(pc_write), .AdrSrc(adr_src),
    .MemWrite(mem_write), .IRWrite(ir_write), .ResultSrc(result_src), .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b), .ALUControl(alu_control), .ImmSrc(imm_src), .RegWrite(reg_write),
    .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );
  multicycle_controller #(.USE_MEM_READY(1'b0), .ILLEGAL_TRAP(1'b0)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Flags(Flags), .mem_ready(mem_ready), .PCWrite(pc_write2), .AdrSrc(adr_src2),
    .MemWrite(mem_write2), .IRWrite(ir_write2), .ResultSrc(result_src2), .ALUSrcA(alu_src_a2),
    .ALUSrcB(alu_src_b2), .ALUControl(alu_control2), .ImmSrc(imm_src2), .RegWrite(reg_write2),
    .illegal_instr(illegal_instr2), .state_dbg(state_dbg2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic set_instr(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[30];
  endtask
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask
  typedef struct {
    string name;
    logic [31:0] ins;
    logic [3:0] flags;
    int cycles;
    int rw_cyc;
    int pcw_cnt;
    logic [3:0] alu2;
  } vec_t;
  vec_t vt[$];
  typedef struct {
    bit rdy, pcw, mw, irw, rw, adr, ca;
    logic [3:0] alu;
    bit ci;
  } cy_t;
  cy_t q[$];
  logic [3:0] f3tbl[8];
  logic [6:0] ops[9];
  logic [2:0] imms[9];
  task automatic push(input bit r, pcw, mw, irw, rw, adr, input bit ca = 1'b0,
                      input logic [3:0] alu = 4'd0, input bit ci = 1'b0);
    q.push_back('{r, pcw, mw, irw, rw, adr, ca, alu, ci});
  endtask
  function automatic bit rb();
    return 1'($urandom);
  endfunction
  function automatic int nw();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction
  function automatic logic [3:0] alu_ref(input bit is_r, input logic [2:0] f3, input bit f7);
    if (f3 == 3'd0 && is_r && f7) return ALU_SUB;
    if (f3 == 3'd5 && f7) return ALU_SRA;
    return f3tbl[f3];
  endfunction
  function automatic bit taken_ref(input logic [2:0] f3, input logic [3:0] fl);
    bit cond;
    if (f3[2:1] == 2'b01) return 1'b0;
    cond = f3[2] == 1'b0 ? fl[2] : f3[1] ? ~fl[1] : fl[3] ^ fl[0];
    return cond ^ f3[0];
  endfunction
  initial begin
    int rw, pc, cyc, w, cls;
    logic [3:0] alu;
    bit done;
    f3tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_BRANCH, OP_LUI, OP_AUIPC};
    imms = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 3'd2, 3'd4, 3'd4};
    vt.push_back('{"add",   32'h002081B3, 4'h0, 4, 3, 1, ALU_ADD});
    vt.push_back('{"sub",   32'h402081B3, 4'h0, 4, 3, 1, ALU_SUB});
    vt.push_back('{"addi7", 32'hC0008093, 4'h0, 4, 3, 1, ALU_ADD});
    vt.push_back('{"srai",  32'h4030D093, 4'h0, 4, 3, 1, ALU_SRA});
    vt.push_back('{"srli",  32'h0030D093, 4'h0, 4, 3, 1, ALU_SRL});
    vt.push_back('{"slt",   32'h0020A1B3, 4'h0, 4, 3, 1, ALU_SLT});
    vt.push_back('{"sltu",  32'h0020B1B3, 4'h0, 4, 3, 1, ALU_SLTU});
    vt.push_back('{"xor",   32'h0020C1B3, 4'h0, 4, 3, 1, ALU_XOR});
    vt.push_back('{"or",    32'h0020E1B3, 4'h0, 4, 3, 1, ALU_OR});
    vt.push_back('{"and",   32'h0020F1B3, 4'h0, 4, 3, 1, ALU_AND});
    vt.push_back('{"sll",   32'h002091B3, 4'h0, 4, 3, 1, ALU_SLL});
    vt.push_back('{"lw",    32'h0000A183, 4'h0, 5, 4, 1, ALU_ADD});
    vt.push_back('{"sw",    32'h0020A023, 4'h0, 4, -1, 1, ALU_ADD});
    vt.push_back('{"beq_t", 32'h00208463, 4'h4, 3, -1, 2, ALU_SUB});
    vt.push_back('{"beq_n", 32'h00208463, 4'h0, 3, -1, 1, ALU_SUB});
    vt.push_back('{"bltu_t",32'h0020E463, 4'h0, 3, -1, 2, ALU_SUB});
    vt.push_back('{"bltu_n",32'h0020E463, 4'h2, 3, -1, 1, ALU_SUB});
    vt.push_back('{"bge_t", 32'h0020D463, 4'h9, 3, -1, 2, ALU_SUB});
    vt.push_back('{"b010",  32'h0020A463, 4'hF, 3, -1, 1, ALU_SUB});
    vt.push_back('{"jal",   32'h008000EF, 4'h0, 4, 3, 2, ALU_ADD});
    vt.push_back('{"jalr",  32'h000100E7, 4'h0, 4, 3, 2, ALU_ADD});
    vt.push_back('{"lui",   32'h000011B7, 4'h0, 4, 3, 1, ALU_PASSB});
    vt.push_back('{"auipc", 32'h00001197, 4'h0, 4, 3, 1, ALU_ADD});
    // reset held with mem_ready high: no enables, state parked in FETCH
    @(posedge clk);
    #1;
    chk("reset_en", 32'({pc_write, mem_write, ir_write, reg_write, illegal_instr}), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(S_FETCH));
    do_reset();
    foreach (vt[i]) begin
      set_instr(vt[i].ins);
      Flags = vt[i].flags;
      mem_ready = 1'b1;
      rw = -1; pc = 0; cyc = 0; alu = 4'd0; done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        if (reg_write && rw < 0) rw = k;
        pc += int'(pc_write);
        if (k == 2) alu = alu_control;
        @(posedge clk);
        #1;
        if (state_dbg == S_FETCH) begin
          done = 1'b1;
          cyc = k + 1;
        end
      end
      chk({vt[i].name, "_cycles"}, cyc, vt[i].cycles);
      chk({vt[i].name, "_rwcyc"}, rw, vt[i].rw_cyc);
      chk({vt[i].name, "_pcw"}, pc, vt[i].pcw_cnt);
      chk({vt[i].name, "_alu"}, 32'(alu), 32'(vt[i].alu2));
    end
    // reset while a store waits on memory
    do_reset();
    set_instr(32'h0020A023);
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait_mw", 32'({mem_write, adr_src}), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("sw_rst_mw", 32'(mem_write), 32'd0);
    chk("sw_rst_state", 32'(state_dbg), 32'(S_FETCH));
    mem_ready = 1'b1;
    #1;
    chk("sw_rst_ir", 32'({ir_write, pc_write}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    chk("sw_rel_state", 32'(state_dbg), 32'(S_FETCH));
    @(negedge clk);
    chk("sw_rel_ir", 32'(ir_write), 32'd1);
    // lw with three memory wait cycles in MEMREAD
    do_reset();
    set_instr(32'h0000A183);
    rw = -1;
    for (int k = 0; k < 9; k++) begin
      mem_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (reg_write && rw < 0) rw = k;
      if (k == 4) chk("lw_wait_adr", 32'(adr_src), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("lw_wait_rw", rw, 7);
    // jalr write-back path
    do_reset();
    set_instr(32'h000100E7);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("jalr_pc", 32'({pc_write, result_src, alu_src_a}), 32'b1_10_10);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("jalr_wb", 32'({reg_write, alu_src_a, alu_src_b}), 32'b1_01_10);
    @(posedge clk);
    #1;
    // illegal opcode: trap in dut, NOP in dut2
    do_reset();
    set_instr(32'h0000007F);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ill_flag", 32'(illegal_instr), 32'd1);
    chk("ill_state", 32'(state_dbg), 32'(S_TRAP));
    chk("nop_state", 32'(state_dbg2), 32'(S_FETCH));
    mem_ready = 1'b0;
    @(negedge clk);
    chk("nop_en", 32'({pc_write2, ir_write2, mem_write2, reg_write2, adr_src2, illegal_instr2}), 32'b110000);
    chk("nop_mux", 32'({result_src2, alu_src_a2, alu_src_b2}), 32'b10_00_10);
    chk("nop_alu", 32'({alu_control2, imm_src2}), 32'({ALU_ADD, 3'd0}));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("ill_hold", 32'({illegal_instr, pc_write, mem_write, ir_write, reg_write}), 32'b10000);
      chk("nop_rw", 32'(reg_write2), 32'd0);
    end
    // random instructions against a per-cycle expectation queue
    do_reset();
    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 8);
      opcode = ops[cls];
      funct3 = 3'($urandom);
      funct7 = rb();
      Flags = 4'($urandom);
      q.delete();
      w = nw();
      repeat (w) push(0, 0, 0, 0, 0, 0);
      push(1, 1, 0, 1, 0, 0);
      push(rb(), 0, 0, 0, 0, 0, 0, 4'd0, cls != 2);
      case (cls)
        0: begin
          push(rb(), 0, 0, 0, 0, 0, 1, ALU_ADD);
          w = nw();
          repeat (w) push(0, 0, 0, 0, 0, 1);
          push(1, 0, 0, 0, 0, 1);
          push(rb(), 0, 0, 0, 1, 0);
        end
        1: begin
          push(rb(), 0, 0, 0, 0, 0, 1, ALU_ADD);
          w = nw();
          repeat (w) push(0, 0, 1, 0, 0, 1);
          push(1, 0, 1, 0, 0, 1);
        end
        2, 3: begin
          push(rb(), 0, 0, 0, 0, 0, 1, alu_ref(cls == 2, funct3, funct7));
          push(rb(), 0, 0, 0, 1, 0);
        end
        4, 5: begin
          push(rb(), 1, 0, 0, 0, 0);
          push(rb(), 0, 0, 0, 1, 0);
        end
        6: push(rb(), taken_ref(funct3, Flags), 0, 0, 0, 0, 1, ALU_SUB);
        7: begin
          push(rb(), 0, 0, 0, 0, 0, 1, ALU_PASSB);
          push(rb(), 0, 0, 0, 1, 0);
        end
        default: begin
          push(rb(), 0, 0, 0, 0, 0, 1, ALU_ADD);
          push(rb(), 0, 0, 0, 1, 0);
        end
      endcase
      foreach (q[i]) begin
        mem_ready = q[i].rdy;
        @(negedge clk);
        chk("rand_ctl", 32'({pc_write, mem_write, ir_write, reg_write, adr_src}),
            32'({q[i].pcw, q[i].mw, q[i].irw, q[i].rw, q[i].adr}));
        if (q[i].ca) chk("rand_alu", 32'(alu_control), 32'(q[i].alu));
        if (q[i].ci) chk("rand_imm", 32'(imm_src), 32'(imms[cls]));
        @(posedge clk);
        #1;
      end
      chk("rand_end", 32'(state_dbg), 32'(S_FETCH));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
